// File: rtl/add_sub_pipe.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into CHUNK-bit stages with a
// valid/ready handshake. Optional macro ADDSUB_SAT_EN clamps Sum on signed overflow.
`timescale 1ns/1ps
module add_sub_pipe #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         OP,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         Zero,
  output logic         Neg
);

  localparam int STAGES = N / CHUNK;
  localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;

  if ((N % CHUNK) != 0) begin : g_bad_chunk
    $error("add_sub_pipe: N must be a multiple of CHUNK");
  end

  function automatic logic [N-1:0] put_chunk(input logic [N-1:0] v, input int k,
                                             input logic [CHUNK-1:0] c);
    logic [N-1:0] r;
    r = v;
    r[k*CHUNK +: CHUNK] = c;
    return r;
  endfunction

`ifdef ADDSUB_SAT_EN
  // Overflow direction follows the sign of A: both effective operands share it.
  function automatic logic [N-1:0] saturate(input logic [N-1:0] s, input logic ovf,
                                            input logic a_msb);
    if (!ovf) return s;
    return a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction
`endif

  logic stall;
  assign stall   = OutValid && !OutReady;
  assign InReady = !stall;

  // Inter-stage registers: operands travel whole, partial sum fills in chunk by chunk.
  logic [N-1:0] a_p   [MID];
  logic [N-1:0] b_p   [MID];
  logic [N-1:0] s_p   [MID];
  logic         cy_p  [MID];
  logic         vld_p [MID];

  logic [N-1:0] src_a [STAGES];
  logic [N-1:0] src_b [STAGES];
  logic [N-1:0] src_s [STAGES];
  logic [N-1:0] nxt_s [STAGES];
  logic         src_c [STAGES];
  logic         src_v [STAGES];
  logic         nxt_c [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_a[k] = A;
      assign src_b[k] = OP ? ~B : B;
      assign src_c[k] = OP;
      assign src_s[k] = '0;
      assign src_v[k] = InValid;
    end else begin : g_next
      assign src_a[k] = a_p[k-1];
      assign src_b[k] = b_p[k-1];
      assign src_c[k] = cy_p[k-1];
      assign src_s[k] = s_p[k-1];
      assign src_v[k] = vld_p[k-1];
    end

    logic [CHUNK:0] chunk_add;
    assign chunk_add = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, src_c[k]};
    assign nxt_s[k] = put_chunk(src_s[k], k, chunk_add[CHUNK-1:0]);
    assign nxt_c[k] = chunk_add[CHUNK];

    if (k < STAGES - 1) begin : g_reg
      // ---- stage k -> stage k+1 boundary ----
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)         vld_p[k] <= 1'b0;
        else if (!stall) vld_p[k] <= src_v[k];
      end

      always_ff @(posedge CLK) begin
        if (!stall && src_v[k]) begin
          a_p[k]  <= src_a[k];
          b_p[k]  <= src_b[k];
          s_p[k]  <= nxt_s[k];
          cy_p[k] <= nxt_c[k];
        end
      end
    end
  end

  logic [N-1:0] raw_sum;
  logic [N-1:0] fin_sum;
  logic         raw_cout;
  logic         msb_cin;
  logic         raw_ovf;

  assign raw_sum  = nxt_s[STAGES-1];
  assign raw_cout = nxt_c[STAGES-1];
  assign msb_cin  = src_a[STAGES-1][N-1] ^ src_b[STAGES-1][N-1] ^ raw_sum[N-1];
  assign raw_ovf  = msb_cin ^ raw_cout;

`ifdef ADDSUB_SAT_EN
  assign fin_sum = saturate(raw_sum, raw_ovf, src_a[STAGES-1][N-1]);
`else
  assign fin_sum = raw_sum;
`endif

  // ---- last stage -> registered outputs ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OutValid <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Ovf      <= 1'b0;
      Zero     <= 1'b0;
      Neg      <= 1'b0;
    end else if (!stall) begin
      OutValid <= src_v[STAGES-1];
      if (src_v[STAGES-1]) begin
        Sum  <= fin_sum;
        Cout <= raw_cout;
        Ovf  <= raw_ovf;
        Zero <= ~|fin_sum;
        Neg  <= fin_sum[N-1];
      end
    end
  end

endmodule
